// File: rtl/wam_scr_acc.sv
// wam_scr_acc: whack-a-mole score accumulator.
// Rising edges on the hole lines are counted individually into a pending-hit
// queue. A small FSM drains the queue one hit at a time. Each hit adds PTS to a
// BCD working copy of the score, one digit per cycle, and then commits the
// result to registered BCD and binary score outputs. A level pulse is issued
// every LVL_HITS committed hits. The score saturates at the all-9s maximum.
module wam_scr_acc #(
  parameter int N_HOLES  = 8,
  parameter int NDIG     = 3,
  parameter int PTS      = 3,
  parameter int LVL_HITS = 10,
  parameter int PEND_W   = 4,
  parameter int BIN_W    = 10
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                en,
  input  logic [N_HOLES-1:0]  hit,
  output logic [4*NDIG-1:0]   score_bcd,
  output logic [BIN_W-1:0]    score_bin,
  output logic                busy,
  output logic                sat,
  output logic                lvl_tick,
  output logic                drop
);

  localparam int MAX   = 10**NDIG - 1;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CNT_W = $clog2(N_HOLES + 1);
  localparam int SUM_W = ((PEND_W > CNT_W) ? PEND_W : CNT_W) + 1;
  localparam int LVL_W = (LVL_HITS > 1) ? $clog2(LVL_HITS) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ADD    = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [BIN_W-1:0]  MAX_BIN  = BIN_W'(MAX);

  // Reject parameter sets the datapath cannot represent.
  generate
    if (MAX >= (2**BIN_W)) begin : g_bin_w_check
      $error("wam_scr_acc: BIN_W too narrow to hold the maximum score");
    end
    if (PTS < 1 || PTS > 9) begin : g_pts_check
      $error("wam_scr_acc: PTS must be a single BCD digit 1..9");
    end
    if (LVL_HITS < 1) begin : g_lvl_check
      $error("wam_scr_acc: LVL_HITS must be at least 1");
    end
  endgenerate

  logic [N_HOLES-1:0] hit_q;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic [1:0]         state_q, state_d;
  logic [3:0]         wrk_q [NDIG];
  logic [3:0]         wrk_d [NDIG];
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               cy_q, cy_d;
  logic [3:0]         bcd_q [NDIG];
  logic [3:0]         bcd_d [NDIG];
  logic [BIN_W-1:0]   score_bin_q, score_bin_d;
  logic               sat_q, sat_d;
  logic [LVL_W-1:0]   lvl_cnt_q, lvl_cnt_d;
  logic               lvl_tick_q, lvl_tick_d;
  logic               drop_q, drop_d;

  logic [N_HOLES-1:0] rise;
  logic [CNT_W-1:0]   nrise;
  logic [SUM_W-1:0]   pend_sum;
  logic [4:0]         digit_sum;
  logic [BIN_W:0]     bin_sum;

  // Per-line rising edges, counted individually so simultaneous hits all score.
  always_comb begin
    rise  = hit & ~hit_q;
    nrise = '0;
    if (en) begin
      for (int i = 0; i < N_HOLES; i++) begin
        nrise = nrise + CNT_W'(rise[i]);
      end
    end
  end

  // Pending queue: add new hits, retire one per commit, clip and flag losses.
  always_comb begin
    pend_sum = SUM_W'(pend_q) + SUM_W'(nrise) - SUM_W'(state_q == ST_COMMIT);
    if (pend_sum > SUM_W'(PEND_MAX)) begin
      pend_d = PEND_MAX;
      drop_d = 1'b1;
    end else begin
      pend_d = pend_sum[PEND_W-1:0];
      drop_d = 1'b0;
    end
  end

  // Scoring FSM: serial BCD add over the working copy, then commit or saturate.
  always_comb begin
    state_d     = state_q;
    wrk_d       = wrk_q;
    idx_d       = idx_q;
    cy_d        = cy_q;
    bcd_d       = bcd_q;
    score_bin_d = score_bin_q;
    sat_d       = sat_q;
    lvl_cnt_d   = lvl_cnt_q;
    lvl_tick_d  = 1'b0;
    digit_sum   = '0;
    bin_sum     = {1'b0, score_bin_q} + (BIN_W+1)'(PTS);

    case (state_q)
      ST_IDLE: begin
        if (pend_q != '0) begin
          wrk_d   = bcd_q;
          idx_d   = '0;
          cy_d    = 1'b0;
          state_d = ST_ADD;
        end
      end

      ST_ADD: begin
        for (int i = 0; i < NDIG; i++) begin
          if (IDX_W'(i) == idx_q) begin
            digit_sum = {1'b0, wrk_q[i]} + ((i == 0) ? 5'(PTS) : {4'b0, cy_q});
            if (digit_sum > 5'd9) begin
              wrk_d[i] = 4'(digit_sum - 5'd10);
              cy_d     = 1'b1;
            end else begin
              wrk_d[i] = digit_sum[3:0];
              cy_d     = 1'b0;
            end
          end
        end
        if (idx_q == IDX_W'(NDIG - 1)) begin
          state_d = ST_COMMIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_COMMIT: begin
        // A carry out of the top digit means the hit would overflow: keep the score.
        if (cy_q) begin
          sat_d = 1'b1;
        end else if (bin_sum > (BIN_W+1)'(MAX)) begin
          for (int i = 0; i < NDIG; i++) begin
            bcd_d[i] = 4'd9;
          end
          score_bin_d = MAX_BIN;
        end else begin
          bcd_d       = wrk_q;
          score_bin_d = bin_sum[BIN_W-1:0];
        end

        if (lvl_cnt_q == LVL_W'(LVL_HITS - 1)) begin
          lvl_cnt_d  = '0;
          lvl_tick_d = 1'b1;
        end else begin
          lvl_cnt_d = lvl_cnt_q + LVL_W'(1);
        end

        // Chain straight into the next hit so back-to-back hits cost NDIG+1 cycles.
        if (pend_d != '0) begin
          wrk_d   = bcd_d;
          idx_d   = '0;
          cy_d    = 1'b0;
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any partial sum in flight.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hit_q       <= '0;
      pend_q      <= '0;
      state_q     <= ST_IDLE;
      wrk_q       <= '{default: 4'd0};
      idx_q       <= '0;
      cy_q        <= 1'b0;
      bcd_q       <= '{default: 4'd0};
      score_bin_q <= '0;
      sat_q       <= 1'b0;
      lvl_cnt_q   <= '0;
      lvl_tick_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      hit_q       <= hit;
      pend_q      <= pend_d;
      state_q     <= state_d;
      wrk_q       <= wrk_d;
      idx_q       <= idx_d;
      cy_q        <= cy_d;
      bcd_q       <= bcd_d;
      score_bin_q <= score_bin_d;
      sat_q       <= sat_d;
      lvl_cnt_q   <= lvl_cnt_d;
      lvl_tick_q  <= lvl_tick_d;
      drop_q      <= drop_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_bcd_out
      assign score_bcd[4*gi +: 4] = bcd_q[gi];
    end
  endgenerate

  assign score_bin = score_bin_q;
  assign busy      = (state_q != ST_IDLE) || (pend_q != '0);
  assign sat       = sat_q;
  assign lvl_tick  = lvl_tick_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_wam_scr_acc.sv
// Directed testbench for wam_scr_acc with default parameters.
module tb_wam_scr_acc;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  hit = '0;
  logic [11:0] score_bcd;
  logic [9:0]  score_bin;
  logic        busy, sat, lvl_tick, drop;

  int errors = 0;
  int checks = 0;
  int tick_cnt = 0;
  int drop_cnt = 0;
  int cyc;

  wam_scr_acc dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .en        (en),
    .hit       (hit),
    .score_bcd (score_bcd),
    .score_bin (score_bin),
    .busy      (busy),
    .sat       (sat),
    .lvl_tick  (lvl_tick),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1ns after the edge, tally the pulse outputs.
  task automatic step();
    @(posedge clk);
    #1;
    if (lvl_tick === 1'b1) tick_cnt++;
    if (drop === 1'b1) drop_cnt++;
  endtask

  task automatic wait_idle(input int budget, output int c);
    c = 0;
    while (busy !== 1'b0 && c < budget) begin
      step();
      c++;
    end
    chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic one_hit(input int hole);
    int c;
    hit[hole] = 1'b1;
    step();
    hit = '0;
    wait_idle(50, c);
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    hit   = '0;
    step();
    step();
    clr_n    = 1'b1;
    tick_cnt = 0;
    drop_cnt = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    en = 1'b1;
    step();
    step();
    chk("rst_bcd", score_bcd, 32'h000);
    chk("rst_bin", score_bin, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_sat", sat, 32'd0);
    chk("rst_lvl_tick", lvl_tick, 32'd0);
    chk("rst_drop", drop, 32'd0);
    clr_n = 1'b1;

    // Single hit: latency E0+5, busy through E0+4 samples
    hit[2] = 1'b1;
    step();
    hit = '0;
    chk("t1_busy_e0", busy, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t1_busy", busy, 32'd1);
    end
    chk("t1_bcd_early", score_bcd, 32'h000);
    step();
    chk("t1_bcd", score_bcd, 32'h003);
    chk("t1_bin", score_bin, 32'd3);
    chk("t1_busy_end", busy, 32'd0);

    // Three simultaneous hits: 1 + 3*(NDIG+1) = 13 cycles to drain
    do_reset();
    hit = 8'b1001_0001;
    step();
    hit = '0;
    wait_idle(100, cyc);
    chk("t2_cycles", cyc, 32'd13);
    chk("t2_bcd", score_bcd, 32'h009);
    chk("t2_bin", score_bin, 32'd9);
    chk("t2_drop", drop_cnt, 32'd0);

    // Level pulses at 10 and 20 hits, carry chain at 34 hits
    do_reset();
    for (int k = 0; k < 9; k++) one_hit(k % 8);
    chk("t5_ticks_9", tick_cnt, 32'd0);
    one_hit(1);
    chk("t5_ticks_10", tick_cnt, 32'd1);
    step();
    chk("t5_tick_low", lvl_tick, 32'd0);
    chk("t5_ticks_once", tick_cnt, 32'd1);
    for (int k = 0; k < 9; k++) one_hit(k % 8);
    chk("t5_ticks_19", tick_cnt, 32'd1);
    one_hit(6);
    chk("t5_ticks_20", tick_cnt, 32'd2);
    chk("t5_bcd_20", score_bcd, 32'h060);
    for (int k = 0; k < 13; k++) one_hit(k % 8);
    chk("t3_bcd_33", score_bcd, 32'h099);
    chk("t3_bin_33", score_bin, 32'd99);
    one_hit(4);
    chk("t3_bcd_34", score_bcd, 32'h102);
    chk("t3_bin_34", score_bin, 32'd102);

    // Saturation at 999
    do_reset();
    for (int k = 0; k < 333; k++) one_hit(k % 8);
    chk("t4_bcd_333", score_bcd, 32'h999);
    chk("t4_bin_333", score_bin, 32'd999);
    chk("t4_sat_333", sat, 32'd0);
    chk("t4_ticks_333", tick_cnt, 32'd33);
    one_hit(0);
    chk("t4_bcd_334", score_bcd, 32'h999);
    chk("t4_bin_334", score_bin, 32'd999);
    chk("t4_sat_334", sat, 32'd1);
    for (int k = 0; k < 6; k++) one_hit(k);
    chk("t4_sat_sticky", sat, 32'd1);
    chk("t4_bcd_340", score_bcd, 32'h999);
    chk("t4_ticks_340", tick_cnt, 32'd34);

    // Queue clipping: 8 rises every 2 cycles, rises at E0..E10
    do_reset();
    for (int k = 0; k < 6; k++) begin
      hit = 8'hFF;
      step();
      hit = '0;
      step();
    end
    chk("t6_drops", drop_cnt, 32'd5);
    chk("t6_busy", busy, 32'd1);
    // en=0: further rises ignored, 15 queued hits still drain
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hit = 8'hFF;
      step();
      hit = '0;
      step();
    end
    wait_idle(300, cyc);
    chk("t6_bcd", score_bcd, 32'h051);
    chk("t6_bin", score_bin, 32'd51);
    chk("t6_drops_end", drop_cnt, 32'd5);

    // Reset in the middle of an add
    en = 1'b1;
    hit[5] = 1'b1;
    step();
    hit = '0;
    step();
    step();
    #2;
    clr_n = 1'b0;
    #1;
    chk("t6_mid_bcd", score_bcd, 32'h000);
    chk("t6_mid_bin", score_bin, 32'd0);
    chk("t6_mid_busy", busy, 32'd0);
    chk("t6_mid_sat", sat, 32'd0);
    chk("t6_mid_tick", lvl_tick, 32'd0);
    chk("t6_mid_drop", drop, 32'd0);
    step();
    clr_n = 1'b1;
    one_hit(3);
    chk("t6_post_bcd", score_bcd, 32'h003);
    chk("t6_post_bin", score_bin, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
